fsm_seq_tx: RTL and testbench

Serial pattern transmitter and the driving end of the seq-detector bit stream. It loads a parallel pattern word on a start/ready handshake and shifts it out MSB-first on x, one bit per clk. The pattern can repeat a programmable number of times, with optional idle gap cycles between repetitions. It is used as the stimulus source in front of the fsm_seq1011 detectors, both on-board and in loopback benches.

---
 rtl/fsm_seq_pkg.sv | 16 +
 rtl/seq_piso.sv | 36 +++
 rtl/fsm_seq_tx.sv | 132 +++++++++++++
 tb/tb_fsm_seq_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encoding and length-width helper for the fsm_seq family
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Width of a field able to hold 0..width inclusive.
    function automatic int len_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_piso.sv
// rtl/seq_piso.sv - parallel-in/serial-out register, MSB-first, pattern top-aligned by length
module seq_piso
    import fsm_seq_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int LW    = len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr;

    // Loading top-aligned drops bits above len-1 and leaves zeros behind the
    // last valid bit, so the serial output is 0 once the pattern is shifted out.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= data << (LW'(WIDTH) - len);
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign bit_out = sr[WIDTH-1];

endmodule

// File: rtl/fsm_seq_tx.sv
// rtl/fsm_seq_tx.sv - serial pattern transmitter with repeat count and optional inter-repeat gap
module fsm_seq_tx
    import fsm_seq_pkg::*;
#(
    parameter int  WIDTH   = 16,
    parameter int  RPT_W   = 4,
    parameter int  GAP_CYC = 0,
    localparam int LW      = len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic [RPT_W-1:0] rpt,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [LW-1:0]    len_eff;
    logic             p_load, p_shift, p_clear;
    logic [WIDTH-1:0] ld_data;
    logic [LW-1:0]    ld_len;

    assign len_eff = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rpt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        gap_d   = gap_q;
        p_load  = 1'b0;
        p_shift = 1'b0;
        p_clear = 1'b0;
        ld_data = pat_q;
        ld_len  = len_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_eff;
                    rpt_d   = rpt;
                    cnt_d   = len_eff - LW'(1);
                    p_load  = 1'b1;
                    ld_data = pattern;
                    ld_len  = len_eff;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - LW'(1);
                    p_shift = 1'b1;
                end else if (rpt_q != '0) begin
                    rpt_d = rpt_q - RPT_W'(1);
                    cnt_d = len_q - LW'(1);
                    // With no gap the reload lands exactly under the next bit slot.
                    if (GAP_CYC > 0) begin
                        p_clear = 1'b1;
                        gap_d   = GW'(GAP_CYC - 1);
                        state_d = GAP;
                    end else begin
                        p_load = 1'b1;
                    end
                end else begin
                    p_shift = 1'b1;
                    state_d = DONE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    p_load  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    seq_piso #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .clr     (clr),
        .load    (p_load),
        .shift   (p_shift),
        .clear   (p_clear),
        .data    (ld_data),
        .len     (ld_len),
        .bit_out (x)
    );

    assign ready   = (state_q == IDLE);
    assign x_valid = (state_q == SHIFT);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_fsm_seq_tx.sv
// tb/tb_fsm_seq_tx.sv - randomized self-checking bench for fsm_seq_tx, gap and no-gap builds side by side
module tb_fsm_seq_tx;

    localparam int WIDTH = 16;
    localparam int RPT_W = 4;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clk     = 1'b0;
    logic             clr     = 1'b0;
    logic             start   = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [LW-1:0]    len     = '0;
    logic [RPT_W-1:0] rpt     = '0;
    logic             ready0, x0, xv0, done0;
    logic             ready2, x2, xv2, done2;

    int vectors = 0;
    int errors  = 0;

    // Expected per-cycle {ready, done, x_valid, x}, one queue per build.
    logic [3:0] exp0[$];
    logic [3:0] exp2[$];

    always #5 clk = ~clk;

    fsm_seq_tx #(.WIDTH(WIDTH), .RPT_W(RPT_W), .GAP_CYC(0)) dut0 (
        .clk(clk), .clr(clr), .start(start), .pattern(pattern), .len(len), .rpt(rpt),
        .ready(ready0), .x(x0), .x_valid(xv0), .done(done0)
    );

    fsm_seq_tx #(.WIDTH(WIDTH), .RPT_W(RPT_W), .GAP_CYC(2)) dut2 (
        .clk(clk), .clr(clr), .start(start), .pattern(pattern), .len(len), .rpt(rpt),
        .ready(ready2), .x(x2), .x_valid(xv2), .done(done2)
    );

    task automatic build(input int d, input logic [WIDTH-1:0] p, input int l, input int r,
                         input bit held, input int n);
        logic [3:0] q[$];
        int el;
        int g;
        el = (l == 0 || l > WIDTH) ? WIDTH : l;
        g  = (d == 0) ? 0 : 2;
        while (q.size() < n) begin
            for (int rr = 0; rr <= r; rr++) begin
                if (rr > 0)
                    for (int i = 0; i < g; i++) q.push_back(4'b0000);
                for (int i = el - 1; i >= 0; i--) q.push_back({3'b001, p[i]});
            end
            q.push_back(4'b0100);
            if (held) q.push_back(4'b1000);
            else while (q.size() < n) q.push_back(4'b1000);
        end
        if (d == 0) exp0 = q;
        else exp2 = q;
    endtask

    task automatic run(input string name, input logic [WIDTH-1:0] p, input int l, input int r,
                       input bit held, input int n_in);
        int n;
        int el;
        logic [3:0] obs;
        el = (l == 0 || l > WIDTH) ? WIDTH : l;
        n  = (n_in > 0) ? n_in : (r + 1) * el + r * 2 + 4;
        build(0, p, l, r, held, n);
        build(2, p, l, r, held, n);
        @(posedge clk); #1;
        pattern = p;
        len     = l[LW-1:0];
        rpt     = r[RPT_W-1:0];
        start   = 1'b1;
        @(posedge clk); #1;
        if (!held) begin
            start   = 1'b0;
            pattern = WIDTH'($urandom);
            len     = LW'($urandom);
            rpt     = RPT_W'($urandom);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs = {ready0, done0, xv0, x0};
            vectors++;
            if (obs !== exp0[k]) begin
                errors++;
                $display("FAIL %s gap0 cycle %0d: got %b want %b", name, k, obs, exp0[k]);
            end
            obs = {ready2, done2, xv2, x2};
            vectors++;
            if (obs !== exp2[k]) begin
                errors++;
                $display("FAIL %s gap2 cycle %0d: got %b want %b", name, k, obs, exp2[k]);
            end
        end
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) clr = 1'b0;
        @(negedge clk) clr = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        obs = {ready0, done0, xv0, x0};
        vectors++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL reset gap0: got %b want 1000", obs);
        end
        obs = {ready2, done2, xv2, x2};
        vectors++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL reset gap2: got %b want 1000", obs);
        end
        clr = 1'b1;
    endtask

    task automatic test_basic();
        run("basic_1011", 16'hA5AB, 4, 0, 1'b0, 0);
        run("loopback16", 16'b0101101100101011, 16, 0, 1'b0, 0);
    endtask

    task automatic test_repeat_gap();
        run("repeat_gap", 16'h0002, 2, 2, 1'b0, 0);
    endtask

    task automatic test_len_edges();
        run("len0", WIDTH'($urandom), 0, 0, 1'b0, 0);
        run("len20", WIDTH'($urandom), 20, 1, 1'b0, 0);
        run("held_start", 16'h0016, 5, 0, 1'b1, 14);
        pulse_reset();
    endtask

    task automatic test_max_rpt();
        run("rpt_max", 16'h0001, 1, 15, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        logic [WIDTH-1:0] p;
        p = WIDTH'($urandom);
        build(0, p, 16, 0, 1'b0, 20);
        @(posedge clk); #1;
        pattern = p; len = LW'(16); rpt = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            obs = {ready0, done0, xv0, x0};
            vectors++;
            if (obs !== exp0[k]) begin
                errors++;
                $display("FAIL reset_mid pre cycle %0d: got %b want %b", k, obs, exp0[k]);
            end
        end
        #1 clr = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            obs = {ready0, done0, xv0, x0};
            vectors++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL reset_mid gap0 step %0d: got %b want 1000", k, obs);
            end
            obs = {ready2, done2, xv2, x2};
            vectors++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL reset_mid gap2 step %0d: got %b want 1000", k, obs);
            end
            @(negedge clk);
        end
        clr = 1'b1;
        run("after_reset", WIDTH'($urandom), 7, 1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run("random", WIDTH'($urandom), $urandom_range(0, 31), $urandom_range(0, 3), 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat_gap();
        test_len_edges();
        test_max_rpt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
